// File: rtl/y86_bus_mem.sv
// Byte-addressed memory responder for the y86 sequential core, with a reset-time
// byte-stream loader that holds the core in reset until the image is complete.
module y86_bus_mem #(
  parameter int ADDR_BITS = 12,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         bus_A,
  input  logic [31:0]         bus_out,
  input  logic                bus_RE,
  input  logic                bus_WE,
  output logic [31:0]         bus_in,
  input  logic                ld_valid,
  input  logic [7:0]          ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                cpu_rst,
  output logic                err,
  output logic [CNT_BITS-1:0] rd_count,
  output logic [CNT_BITS-1:0] wr_count
);

  localparam int MEM_SIZE = 1 << ADDR_BITS;

  typedef enum logic {LOAD, RUN} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] ptr;
  logic [7:0]           mem [MEM_SIZE];

  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic                 oor;
  logic                 in_run;
  logic                 ld_accept;
  logic                 bus_wr;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + CNT_BITS'(1);
  endfunction

  // Byte lanes wrap modulo the memory size so unaligned fetches near the top work.
  assign a0        = bus_A[ADDR_BITS-1:0];
  assign a1        = a0 + ADDR_BITS'(1);
  assign a2        = a0 + ADDR_BITS'(2);
  assign a3        = a0 + ADDR_BITS'(3);
  assign oor       = |bus_A[31:ADDR_BITS];
  assign in_run    = (state == RUN);
  assign ld_accept = (state == LOAD) && ld_valid;
  assign bus_wr    = in_run && bus_WE && !oor;

  always_comb begin
    bus_in = '0;
    if (in_run && bus_RE && !oor)
      bus_in = {mem[a3], mem[a2], mem[a1], mem[a0]};
  end

  // Array is never cleared; a reset edge only blocks the write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (ld_accept)
        mem[ptr] <= ld_data;
      if (bus_wr) begin
        mem[a0] <= bus_out[7:0];
        mem[a1] <= bus_out[15:8];
        mem[a2] <= bus_out[23:16];
        mem[a3] <= bus_out[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LOAD;
      ptr      <= '0;
      cpu_rst  <= 1'b1;
      ld_ready <= 1'b1;
      err      <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_valid) begin
            ptr <= ptr + ADDR_BITS'(1);
            if (&ptr)
              err <= 1'b1;
            if (ld_last) begin
              state    <= RUN;
              cpu_rst  <= 1'b0;
              ld_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          if (bus_RE)
            rd_count <= sat_inc(rd_count);
          if (bus_WE)
            wr_count <= sat_inc(wr_count);
          if (((bus_RE || bus_WE) && oor) || (bus_RE && bus_WE))
            err <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_bus_mem.sv
// Directed bench for y86_bus_mem: load, unaligned fetch, wrap store, range errors,
// RE/WE collision, mid-run reset, loader pointer wrap and counter saturation.
module tb_y86_bus_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_A;
  logic [31:0] bus_out;
  logic        bus_RE;
  logic        bus_WE;
  logic [31:0] bus_in;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic        err;
  logic [3:0]  rd_count;
  logic [3:0]  wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  y86_bus_mem #(.ADDR_BITS(12), .CNT_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_A    (bus_A),
    .bus_out  (bus_out),
    .bus_RE   (bus_RE),
    .bus_WE   (bus_WE),
    .bus_in   (bus_in),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .err      (err),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Streams n bytes of value (base+i) mod 256, ld_last on the final byte.
  task automatic load_bytes(input int n, input int base, input bit watch);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'((base + i) & 8'hFF);
      ld_last  = (i == n - 1);
      #1;
      if (watch) begin
        chk("ld_ready_during_load", {31'd0, ld_ready}, 32'd1);
        chk("cpu_rst_during_load", {31'd0, cpu_rst}, 32'd1);
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 8'h00;
  endtask

  initial begin
    rst = 1'b0; bus_A = '0; bus_out = '0; bus_RE = 1'b0; bus_WE = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick();
    tick();

    // Reset state; strobes in LOAD are ignored and read data is zero
    bus_RE = 1'b1; bus_A = 32'h0;
    #1;
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_count", {28'd0, rd_count}, 32'd0);
    chk("rst_wr_count", {28'd0, wr_count}, 32'd0);
    chk("load_bus_in_zero", bus_in, 32'h0);

    rst = 1'b1;
    load_bytes(4, 1, 1'b1);
    chk("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("run_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("load_rd_count_idle", {28'd0, rd_count}, 32'd0);
    bus_RE = 1'b1; bus_A = 32'h0;
    #1;
    chk("read_aligned", bus_in, 32'h04030201);
    tick();
    chk("rd_count_1", {28'd0, rd_count}, 32'd1);
    bus_RE = 1'b0;
    #1;
    chk("bus_in_re_low", bus_in, 32'h0);

    // Reload 10..17 and fetch unaligned
    rst = 1'b0; tick(); rst = 1'b1;
    load_bytes(8, 8'h10, 1'b0);
    bus_RE = 1'b1; bus_A = 32'h3;
    #1;
    chk("read_unaligned", bus_in, 32'h16151413);
    tick();
    bus_RE = 1'b0;

    // Store wrapping around the top of memory
    bus_WE = 1'b1; bus_A = 32'hFFE; bus_out = 32'hAABBCCDD;
    tick();
    bus_WE = 1'b0; bus_RE = 1'b1;
    #1;
    chk("wrap_readback", bus_in, 32'hAABBCCDD);
    bus_A = 32'h0;
    #1;
    chk("wrap_low_bytes", bus_in, 32'h1312AABB);
    chk("wrap_wr_count", {28'd0, wr_count}, 32'd1);
    chk("wrap_err", {31'd0, err}, 32'd0);
    tick();
    bus_RE = 1'b0;

    // Out-of-range store is suppressed and flags err
    bus_WE = 1'b1; bus_A = 32'h1000; bus_out = 32'hFFFFFFFF;
    tick();
    bus_WE = 1'b0;
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_wr_count", {28'd0, wr_count}, 32'd2);
    bus_RE = 1'b1; bus_A = 32'h0;
    #1;
    chk("oor_mem_unchanged", bus_in, 32'h1312AABB);
    tick();
    bus_A = 32'h1000;
    #1;
    chk("oor_read_zero", bus_in, 32'h0);
    tick();
    chk("oor_err_sticky", {31'd0, err}, 32'd1);
    chk("oor_rd_count", {28'd0, rd_count}, 32'd4);
    bus_A = 32'h0;
    tick();
    chk("five_reads", {28'd0, rd_count}, 32'd5);

    // Reset mid-run
    rst = 1'b0; tick(); rst = 1'b1;
    chk("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("midrst_rd_count", {28'd0, rd_count}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_bus_in", bus_in, 32'h0);
    tick();
    chk("midrst_no_count", {28'd0, rd_count}, 32'd0);
    bus_RE = 1'b0;
    load_bytes(4, 8'hA0, 1'b0);

    // Simultaneous read and write returns pre-write data
    bus_RE = 1'b1; bus_WE = 1'b1; bus_A = 32'h0; bus_out = 32'h11223344;
    #1;
    chk("rw_pre_write", bus_in, 32'hA3A2A1A0);
    tick();
    bus_WE = 1'b0;
    chk("rw_err", {31'd0, err}, 32'd1);
    chk("rw_rd_count", {28'd0, rd_count}, 32'd1);
    chk("rw_wr_count", {28'd0, wr_count}, 32'd1);
    #1;
    chk("rw_post_write", bus_in, 32'h11223344);

    // Saturation
    for (int i = 0; i < 20; i++) tick();
    chk("rd_count_sat", {28'd0, rd_count}, 32'd15);
    chk("wr_count_hold", {28'd0, wr_count}, 32'd1);
    bus_RE = 1'b0;

    // Loader pointer wrap: 4097 bytes, last lands on address 0
    rst = 1'b0; tick(); rst = 1'b1;
    load_bytes(4097, 5, 1'b0);
    chk("ldwrap_err", {31'd0, err}, 32'd1);
    chk("ldwrap_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    bus_RE = 1'b1; bus_A = 32'h0;
    #1;
    chk("ldwrap_data", bus_in, 32'h08070605);
    ld_valid = 1'b1; ld_data = 8'hEE;
    tick();
    ld_valid = 1'b0;
    chk("run_ignores_loader", bus_in, 32'h08070605);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
